// File: rtl/gfx_wc_pkg.sv
// Shared types and alignment helpers for the pixel write combiner and its read-side counterpart.
package gfx_wc_pkg;

    localparam int unsigned MAX_LB    = 128;
    localparam int unsigned MAX_OFS_W = 7;

    localparam int unsigned DEF_MEM_W = 256;
    localparam int unsigned DEF_ADR_W = 32;
    localparam int unsigned DEF_LB    = DEF_MEM_W / 8;
    localparam int unsigned DEF_OFS_W = $clog2(DEF_LB);

    typedef enum logic [1:0] {
        D8  = 2'd0,
        D16 = 2'd1,
        D24 = 2'd2,
        D32 = 2'd3
    } depth_t;

    // Memory line at the default geometry; the combiner builds the same shape from its parameters.
    typedef struct packed {
        logic [DEF_ADR_W-DEF_OFS_W-1:0] tag;
        logic [DEF_MEM_W-1:0]           dat;
        logic [DEF_LB-1:0]              sel;
    } line_t;

    function automatic logic [31:0] depth_mask(depth_t depth);
        logic [31:0] m;
        case (depth)
            D8:      m = 32'h0000_00FF;
            D16:     m = 32'h0000_FFFF;
            D24:     m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Byte lanes of one pixel at byte offset ofs; caller truncates to its line width.
    function automatic logic [MAX_LB-1:0] lane_mask(depth_t depth, logic [MAX_OFS_W-1:0] ofs);
        logic [3:0] m;
        case (depth)
            D8:      m = 4'h1;
            D16:     m = 4'h3;
            D24:     m = 4'h7;
            default: m = 4'hF;
        endcase
        return MAX_LB'(m) << ofs;
    endfunction

endpackage

// File: rtl/gfx_pixel_write_combiner_if.sv
// Pixel-in / line-out bus of the write combiner; slave is the combiner side.
interface gfx_pixel_write_combiner_if #(
    parameter int unsigned MEM_W = 256,
    parameter int unsigned ADR_W = 32
);
    import gfx_wc_pkg::*;

    localparam int unsigned LB = MEM_W / 8;

    logic             s_valid_i;
    logic             s_ready_o;
    logic [ADR_W-1:0] s_adr_i;
    logic [31:0]      s_color_i;
    depth_t           s_depth_i;
    logic             flush_i;
    logic             m_valid_o;
    logic             m_ack_i;
    logic [ADR_W-1:0] m_adr_o;
    logic [MEM_W-1:0] m_dat_o;
    logic [LB-1:0]    m_sel_o;
    logic             idle_o;
    logic             trunc_o;

    modport slave (
        input  s_valid_i, s_adr_i, s_color_i, s_depth_i, flush_i, m_ack_i,
        output s_ready_o, m_valid_o, m_adr_o, m_dat_o, m_sel_o, idle_o, trunc_o
    );

    modport master (
        output s_valid_i, s_adr_i, s_color_i, s_depth_i, flush_i, m_ack_i,
        input  s_ready_o, m_valid_o, m_adr_o, m_dat_o, m_sel_o, idle_o, trunc_o
    );

endinterface

// File: rtl/gfx_pixel_align.sv
// Combinational aligner: places one 8..32bpp pixel into a MEM_W-bit line and flags spill past the line end.
module gfx_pixel_align
    import gfx_wc_pkg::*;
#(
    parameter  int unsigned MEM_W = 256,
    localparam int unsigned LB    = MEM_W / 8,
    localparam int unsigned OFS_W = $clog2(LB)
) (
    input  logic [OFS_W-1:0] ofs,
    input  logic [31:0]      color,
    input  depth_t           depth,
    output logic [LB-1:0]    lane_c,
    output logic [MEM_W-1:0] data_c,
    output logic             trunc_c
);
    localparam int unsigned SUM_W = OFS_W + 1;

    assign lane_c  = LB'(lane_mask(depth, MAX_OFS_W'(ofs)));
    assign data_c  = MEM_W'(color & depth_mask(depth)) << {ofs, 3'b000};

    // Last byte of the pixel lands at ofs+depth; anything beyond LB-1 is dropped.
    assign trunc_c = (SUM_W'(ofs) + SUM_W'(depth)) > SUM_W'(LB - 1);

endmodule

// File: rtl/gfx_pixel_write_combiner.sv
// Merges single-pixel writes into full-width masked line writes through a combining buffer and output register.
module gfx_pixel_write_combiner
    import gfx_wc_pkg::*;
#(
    parameter int unsigned MEM_W   = 256,
    parameter int unsigned ADR_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    gfx_pixel_write_combiner_if.slave  bus
);
    localparam int unsigned LB    = MEM_W / 8;
    localparam int unsigned OFS_W = $clog2(LB);
    localparam int unsigned TAG_W = ADR_W - OFS_W;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [MEM_W-1:0] dat;
        logic [LB-1:0]    sel;
    } wline_t;

    wline_t           buf_q, buf_d, out_q, out_d;
    logic             buf_v_q, buf_v_d;
    logic             out_v_q, out_v_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             idle_q, trunc_q;

    logic [TAG_W-1:0] s_tag;
    logic [OFS_W-1:0] s_ofs;
    logic [LB-1:0]    a_lane;
    logic [MEM_W-1:0] a_data;
    logic             a_trunc;
    logic             hit, sel_full, t_exp, fc, xf, s_ready_c, acc;

    assign s_tag = bus.s_adr_i[ADR_W-1:OFS_W];
    assign s_ofs = bus.s_adr_i[OFS_W-1:0];

    gfx_pixel_align #(.MEM_W(MEM_W)) u_align (
        .ofs     (s_ofs),
        .color   (bus.s_color_i),
        .depth   (bus.s_depth_i),
        .lane_c  (a_lane),
        .data_c  (a_data),
        .trunc_c (a_trunc)
    );

    // Buffer leaves on a miss, a full line, a pending flush or an idle timeout; output must be free or draining.
    assign hit       = buf_v_q && (buf_q.tag == s_tag);
    assign sel_full  = &buf_q.sel;
    assign t_exp     = (TIMEOUT != 0) && (tcnt_q == CNT_W'(TIMEOUT));
    assign fc        = buf_v_q && ((bus.s_valid_i && !hit) || sel_full || flush_q || t_exp);
    assign xf        = fc && (!out_v_q || bus.m_ack_i);
    assign s_ready_c = !flush_q && (!buf_v_q || (hit && !sel_full) || xf);
    assign acc       = bus.s_valid_i && s_ready_c;

    // Next state of buffer, output register, flush tracking and timeout counter.
    always_comb begin
        buf_d   = buf_q;
        buf_v_d = buf_v_q;
        out_d   = out_q;
        out_v_d = out_v_q;
        flush_d = flush_q;
        tcnt_d  = tcnt_q;

        // A pixel accepted while the buffer departs always starts a fresh line, even for the same tag.
        if (acc && (xf || !buf_v_q)) begin
            buf_v_d     = 1'b1;
            buf_d.tag   = s_tag;
            buf_d.dat   = a_data;
            buf_d.sel   = a_lane;
        end else if (acc) begin
            for (int b = 0; b < int'(LB); b++) begin
                if (a_lane[b]) begin
                    buf_d.dat[8*b +: 8] = a_data[8*b +: 8];
                end
            end
            buf_d.sel = buf_q.sel | a_lane;
        end else if (xf) begin
            buf_v_d = 1'b0;
        end

        if (xf) begin
            out_d   = buf_q;
            out_v_d = 1'b1;
        end else if (bus.m_ack_i) begin
            out_v_d = 1'b0;
        end

        if (flush_q && !buf_v_q && !out_v_q) begin
            flush_d = 1'b0;
        end else if (bus.flush_i && (buf_v_q || out_v_q)) begin
            flush_d = 1'b1;
        end

        if (acc || xf || !buf_v_q) begin
            tcnt_d = '0;
        end else if (tcnt_q != CNT_W'(TIMEOUT)) begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q   <= '0;
            buf_v_q <= 1'b0;
            out_q   <= '0;
            out_v_q <= 1'b0;
            flush_q <= 1'b0;
            tcnt_q  <= '0;
            idle_q  <= 1'b1;
            trunc_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            buf_v_q <= buf_v_d;
            out_q   <= out_d;
            out_v_q <= out_v_d;
            flush_q <= flush_d;
            tcnt_q  <= tcnt_d;
            idle_q  <= !buf_v_d && !out_v_d && !flush_d;
            trunc_q <= acc && a_trunc;
        end
    end

    assign bus.s_ready_o = s_ready_c;
    assign bus.m_valid_o = out_v_q;
    assign bus.m_adr_o   = {out_q.tag, OFS_W'(0)};
    assign bus.m_dat_o   = out_q.dat;
    assign bus.m_sel_o   = out_q.sel;
    assign bus.idle_o    = idle_q;
    assign bus.trunc_o   = trunc_q;

endmodule

// File: tb/tb_gfx_pixel_write_combiner.sv
// Directed bench for gfx_pixel_write_combiner at MEM_W=256, ADR_W=32, TIMEOUT=16.
module tb_gfx_pixel_write_combiner;
    import gfx_wc_pkg::*;

    localparam int unsigned MEM_W = 256;
    localparam int unsigned ADR_W = 32;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] col;
        depth_t      d;
        line_t       exp;
        logic        trunc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    gfx_pixel_write_combiner_if #(.MEM_W(MEM_W), .ADR_W(ADR_W)) bus ();

    gfx_pixel_write_combiner #(.MEM_W(MEM_W), .ADR_W(ADR_W), .TIMEOUT(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chkw(input string name, input logic [MEM_W-1:0] act, input logic [MEM_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic line_t mk_line(input logic [31:0] adr, input logic [31:0] sel, input logic [255:0] dat);
        line_t l;
        l.tag = 27'(adr >> 5);
        l.sel = sel;
        l.dat = dat;
        return l;
    endfunction

    task automatic drive_px(input logic [31:0] adr, input logic [31:0] col, input depth_t d);
        bus.s_valid_i = 1'b1;
        bus.s_adr_i   = adr;
        bus.s_color_i = col;
        bus.s_depth_i = d;
    endtask

    task automatic chk_line(input string name, input line_t exp);
        chkw({name, "_adr"}, MEM_W'(bus.m_adr_o), MEM_W'({exp.tag, 5'b00000}));
        chkw({name, "_sel"}, MEM_W'(bus.m_sel_o), MEM_W'(exp.sel));
        chkw({name, "_dat"}, bus.m_dat_o, exp.dat);
    endtask

    task automatic wait_mvalid(input string name, input int budget);
        int n = 0;
        while (bus.m_valid_o !== 1'b1 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk1({name, "_mvalid"}, bus.m_valid_o, 1'b1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.idle_o !== 1'b1 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk1({name, "_idle"}, bus.idle_o, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[7];
        logic [255:0] exp_dat;
        int          bad;
        int          nw;

        vecs[0] = '{32'h0000_5000, 32'h1234_56AB, D8,  mk_line(32'h5000, 32'h0000_0001, 256'hAB), 1'b0};
        vecs[1] = '{32'h0000_5043, 32'hDEAD_BEEF, D16, mk_line(32'h5040, 32'h0000_0018, 256'(32'hBEEF) << 24), 1'b0};
        vecs[2] = '{32'h0000_6025, 32'hFF11_2233, D24, mk_line(32'h6020, 32'h0000_00E0, 256'(32'h112233) << 40), 1'b0};
        vecs[3] = '{32'h0000_7FFE, 32'hCAFE_F00D, D32, mk_line(32'h7FE0, 32'hC000_0000, 256'(32'hF00D) << 240), 1'b1};
        vecs[4] = '{32'h0000_801F, 32'h0000_005A, D8,  mk_line(32'h8000, 32'h8000_0000, 256'(32'h5A) << 248), 1'b0};
        vecs[5] = '{32'h0000_901F, 32'h0000_1234, D16, mk_line(32'h9000, 32'h8000_0000, 256'(32'h34) << 248), 1'b1};
        vecs[6] = '{32'h0000_A01C, 32'h0102_0304, D32, mk_line(32'hA000, 32'hF000_0000, 256'(32'h01020304) << 224), 1'b0};

        bus.s_valid_i = 1'b0;
        bus.s_adr_i   = '0;
        bus.s_color_i = '0;
        bus.s_depth_i = D8;
        bus.flush_i   = 1'b0;
        bus.m_ack_i   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_mvalid", bus.m_valid_o, 1'b0);
        chk1("rst_idle", bus.idle_o, 1'b1);
        chk1("rst_trunc", bus.trunc_o, 1'b0);
        chkw("rst_sel", MEM_W'(bus.m_sel_o), '0);
        chkw("rst_dat", bus.m_dat_o, '0);
        chkw("rst_adr", MEM_W'(bus.m_adr_o), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("rst_ready", bus.s_ready_o, 1'b1);

        // Single-pixel alignment vectors, each pushed out by a flush
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_px(vecs[i].adr, vecs[i].col, vecs[i].d);
            #1;
            chk1($sformatf("v%0d_ready", i), bus.s_ready_o, 1'b1);
            @(negedge clk);
            bus.s_valid_i = 1'b0;
            bus.flush_i   = 1'b1;
            #1;
            chk1($sformatf("v%0d_trunc", i), bus.trunc_o, vecs[i].trunc);
            chk1($sformatf("v%0d_held", i), bus.m_valid_o, 1'b0);
            @(negedge clk);
            bus.flush_i = 1'b0;
            #1;
            chk1($sformatf("v%0d_trunc_end", i), bus.trunc_o, 1'b0);
            wait_mvalid($sformatf("v%0d", i), 6);
            chk_line($sformatf("v%0d", i), vecs[i].exp);
            wait_idle($sformatf("v%0d", i), 8);
        end

        // Flush while idle does nothing
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        chk1("idleflush_idle", bus.idle_o, 1'b1);
        chk1("idleflush_ready", bus.s_ready_o, 1'b1);

        // 32 consecutive 8bpp pixels fill one line
        bad = 0;
        exp_dat = '0;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            drive_px(32'h1000 + 32'(n), 32'(n), D8);
            exp_dat[8*n +: 8] = 8'(n);
            #1;
            if (bus.s_ready_o !== 1'b1) bad++;
        end
        chki("fill_ready_drops", bad, 0);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        #1;
        chk1("fill_early", bus.m_valid_o, 1'b0);
        @(negedge clk);
        #1;
        chk1("fill_mvalid", bus.m_valid_o, 1'b1);
        chk_line("fill", mk_line(32'h1000, 32'hFFFF_FFFF, exp_dat));
        nw = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (bus.m_valid_o === 1'b1) nw++;
        end
        chki("fill_extra_writes", nw, 0);

        // Miss evicts the first line; the second waits for the timeout
        @(negedge clk);
        drive_px(32'h2004, 32'h0000_BEEF, D16);
        #1;
        chk1("to_ready0", bus.s_ready_o, 1'b1);
        @(negedge clk);
        drive_px(32'h3000, 32'h0000_C0DE, D16);
        #1;
        chk1("to_ready1", bus.s_ready_o, 1'b1);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        #1;
        chk1("to_first_mvalid", bus.m_valid_o, 1'b1);
        chk_line("to_first", mk_line(32'h2000, 32'h0000_0030, 256'(32'hBEEF) << 32));
        nw = 0;
        repeat (16) begin
            @(negedge clk); #1;
            if (bus.m_valid_o === 1'b1) nw++;
        end
        chki("to_quiet", nw, 0);
        @(negedge clk);
        #1;
        chk1("to_fire", bus.m_valid_o, 1'b1);
        chk_line("to_second", mk_line(32'h3000, 32'h0000_0003, 256'(32'hC0DE)));
        wait_idle("to", 8);

        // Later pixel overwrites an earlier one on the same lanes
        @(negedge clk);
        drive_px(32'h4008, 32'hAABB_CCDD, D32);
        @(negedge clk);
        drive_px(32'h4008, 32'h1122_3344, D32);
        #1;
        chk1("ovw_ready", bus.s_ready_o, 1'b1);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        bus.flush_i   = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        wait_mvalid("ovw", 6);
        chk_line("ovw", mk_line(32'h4000, 32'h0000_0F00, 256'(32'h11223344) << 64));
        nw = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (bus.m_valid_o === 1'b1) nw++;
        end
        chki("ovw_single_write", nw, 0);
        wait_idle("ovw", 8);

        // Back-pressure: output and buffer both occupied, a miss must stall
        bus.m_ack_i = 1'b0;
        @(negedge clk);
        drive_px(32'h5000, 32'h11, D8);
        @(negedge clk);
        drive_px(32'h5100, 32'h22, D8);
        #1;
        chk1("bp_ready_y", bus.s_ready_o, 1'b1);
        bad = 0;
        nw = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive_px(32'h5200, 32'h33, D8);
            #1;
            if (bus.s_ready_o !== 1'b0) bad++;
            if (bus.m_valid_o !== 1'b1 || bus.m_adr_o !== 32'h5000 ||
                bus.m_sel_o !== 32'h1 || bus.m_dat_o !== 256'h11) nw++;
        end
        chki("bp_ready_high", bad, 0);
        chki("bp_out_unstable", nw, 0);
        @(negedge clk);
        bus.m_ack_i = 1'b1;
        #1;
        chk1("bp_release_ready", bus.s_ready_o, 1'b1);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        bus.flush_i   = 1'b1;
        #1;
        chk1("bp_y_mvalid", bus.m_valid_o, 1'b1);
        chk_line("bp_y", mk_line(32'h5100, 32'h1, 256'h22));
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        wait_mvalid("bp_z", 6);
        chk_line("bp_z", mk_line(32'h5200, 32'h1, 256'h33));
        wait_idle("bp", 8);

        // Flush with three pixels buffered blocks input until drained
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_px(32'h6000 + 32'(k), 32'hA1 + 32'(k), D8);
            #1;
            if (bus.s_ready_o !== 1'b1) bad++;
        end
        chki("fl_ready_drops", bad, 0);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        bus.flush_i   = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        chk1("fl_blocked", bus.s_ready_o, 1'b0);
        wait_mvalid("fl", 6);
        chk_line("fl", mk_line(32'h6000, 32'h0000_0007, 256'hA3A2A1));
        chk1("fl_blocked_out", bus.s_ready_o, 1'b0);
        bad = 0;
        for (int k = 0; k < 8 && bus.idle_o !== 1'b1; k++) begin
            @(negedge clk); #1;
            if (bus.idle_o !== 1'b1 && bus.s_ready_o === 1'b1) bad++;
        end
        chki("fl_ready_while_pending", bad, 0);
        chk1("fl_idle", bus.idle_o, 1'b1);
        chk1("fl_ready_after", bus.s_ready_o, 1'b1);

        // Asynchronous reset with a write on the port and a line buffered
        bus.m_ack_i = 1'b0;
        @(negedge clk);
        drive_px(32'h7000, 32'h77, D8);
        @(negedge clk);
        drive_px(32'h7100, 32'h88, D8);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        #1;
        chk1("ar_mvalid_before", bus.m_valid_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("ar_mvalid", bus.m_valid_o, 1'b0);
        chkw("ar_sel", MEM_W'(bus.m_sel_o), '0);
        chkw("ar_dat", bus.m_dat_o, '0);
        chkw("ar_adr", MEM_W'(bus.m_adr_o), '0);
        chk1("ar_idle", bus.idle_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.m_ack_i = 1'b1;
        nw = 0;
        repeat (24) begin
            @(negedge clk); #1;
            if (bus.m_valid_o === 1'b1) nw++;
        end
        chki("ar_no_write", nw, 0);
        chk1("ar_idle_after", bus.idle_o, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gfx_pixel_write_combiner.md
Name: gfx_pixel_write_combiner

Overview:
- Pipelined successor to the combinational colour-to-memory aligner.
- Accepts a stream of single-pixel writes: byte address, colour, colour depth.
- Aligns each pixel into a MEM_W-bit memory line and merges successive pixels to the same line in a combining buffer.
- Issues one masked full-width line write per line. Sits between the raster/blit pixel pipeline and the wide memory write port.

Parameters:
- MEM_W, 256, memory data width in bits; power of two, 64..1024. LB = MEM_W/8 bytes per line; OFS_W = log2(LB).
- ADR_W, 32, byte-address width.
- TIMEOUT, 16, idle cycles before an occupied buffer auto-flushes. 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- s_valid_i  in  1  pixel write valid
- s_ready_o  out  1  pixel accepted when s_valid_i & s_ready_o
- s_adr_i  in  ADR_W  pixel byte address
- s_color_i  in  32  pixel colour, LSB-aligned
- s_depth_i  in  2  bytes per pixel minus 1 (0 = 8bpp … 3 = 32bpp)
- flush_i  in  1  single-cycle flush request
- m_valid_o  out  1  line write valid
- m_ack_i  in  1  line write accepted
- m_adr_o  out  ADR_W  line byte address, low OFS_W bits zero
- m_dat_o  out  MEM_W  line data
- m_sel_o  out  LB  byte enables
- idle_o  out  1  buffer empty & output empty & no flush pending
- trunc_o  out  1  one-cycle pulse: accepted pixel spilled past the line end

Behaviour:
- Reset: buffer and output register invalid; m_valid_o, m_dat_o, m_sel_o, m_adr_o, trunc_o = 0; timeout counter = 0; flush pending = 0; idle_o = 1; s_ready_o = 1 after reset release.
- Alignment, per accepted pixel:
  - ofs = s_adr_i[OFS_W-1:0].
  - Lane mask = ((1 << (depth+1)) - 1) << ofs, truncated to LB bits.
  - Data = (colour & depth mask) << (8*ofs).
  - Bytes beyond the line end are dropped and trunc_o pulses on the next cycle.
- Two storage stages: combining buffer (tag, dat, sel, buf_v) and output register (m_*; m_valid_o = out_v).
- hit = buf_v & tag == s_adr_i[ADR_W-1:OFS_W].
- Merge: on acceptance with hit, for each byte with a new lane bit set, buffer byte := new byte and sel bit := 1. A later pixel overwrites an earlier one.
- Flush condition (fc): buf_v & (s_valid_i & !hit | all sel bits set | flush pending | timeout expired).
- Transfer (xf) = fc & (!out_v | m_ack_i). Buffer moves to the output register; buf_v clears unless reloaded the same cycle.
- s_ready_o = !flush pending & (!buf_v | (hit & !(all sel set)) | xf). Combinational from m_ack_i.
  - On an xf cycle with an accepted pixel, the pixel loads a fresh buffer (sel = its lanes only), even when its line equals the departing tag.
- Output register:
  - Holds stable while m_valid_o & !m_ack_i.
  - On m_ack_i without xf, out_v clears.
  - On m_ack_i with xf, new line replaces it the same cycle (back-to-back, no bubble).
- flush_i:
  - Sets flush pending, which blocks s_ready_o.
  - Pending clears the first cycle buffer and output are both empty.
  - flush_i while already idle is a no-op; idle_o stays 1.
- Timeout counter:
  - Resets on each accepted pixel and on buffer load.
  - Counts while buf_v; saturates at TIMEOUT.
  - Expired when it equals TIMEOUT and TIMEOUT != 0.
- Latency: a pixel reaches m_valid_o no earlier than 1 cycle after its flush condition. Minimum accept-to-m_valid is 2 cycles.
- Memory order equals acceptance order; lines never reorder.
- Asynchronous reset mid-transfer discards buffered and pending data without emitting a write.

Decomposition:
- Package gfx_wc_pkg:
  - depth_t (2-bit enum D8/D16/D24/D32).
  - Function lane_mask(depth, ofs) and function depth_mask(depth).
  - Line struct {tag, dat, sel}.
- Sub-module gfx_pixel_align: combinational aligner producing lane mask, shifted data and trunc flag, parametrised by MEM_W. Reused by the read-side unpacker later.

Test Plan:
- MEM_W=256: 32 consecutive 8bpp pixels at 0x1000..0x101F, colour = byte index, m_ack_i held 1 → exactly one write: adr 0x1000, sel 0xFFFFFFFF, dat byte n = n, issued on the cycle after the last pixel.
- 16bpp pixels at 0x2004 then 0x3000 → first write adr 0x2000, sel 0x00000030; second line stays buffered until TIMEOUT=16 idle cycles, then writes sel 0x00000003.
- Two 32bpp writes to 0x4008: 0xAABBCCDD then 0x11223344 → single write, sel 0x00000F00, dat bytes 8..11 = 44 33 22 11.
- 32bpp pixel at offset 30 → sel bits 30,31 only, trunc_o pulses once.
- m_ack_i held low 10 cycles with output full and buffer full → s_ready_o low on a miss pixel, m_* stable. Ack releases both lines in order with no bubble.
- flush_i mid-accumulation with 3 pixels buffered → s_ready_o low until the line is acked, then idle_o = 1. Async reset asserted while m_valid_o=1 → all outputs 0 immediately.
